// File: rtl/elixirchip_es1_bram_read_arbiter.sv
// Round-robin arbiter sharing the ES1 RAMB18E2 read port (DOUT_REGS=1) among NUM_REQ requesters, with a
// credit-guarded show-ahead response FIFO. Optional: ELIXIRCHIP_BRAM_ARB_COLLISION_STALL_EN stalls same-address reads.
module elixirchip_es1_bram_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_BITS    = $clog2(NUM_REQ),
    parameter int ADDR_BITS  = 10,
    parameter int DATA_WIDTH = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*ADDR_BITS-1:0] req_addr,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_BITS-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    input  logic                         wr_en,
    input  logic [ADDR_BITS-1:0]         wr_addr,
    output logic                         ram_en,
    output logic                         ram_regcke,
    output logic [ADDR_BITS-1:0]         ram_addr,
    input  logic [DATA_WIDTH-1:0]        ram_dout
);

    localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_BITS = $clog2(FIFO_DEPTH + 1);

    logic [ID_BITS-1:0]    rr_q, rr_d;
    logic                  v1_q, v1_d, v2_q, v2_d;
    logic [ID_BITS-1:0]    tag1_q, tag1_d, tag2_q, tag2_d;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_BITS-1:0]    rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [ID_BITS-1:0]    fifo_id_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];

    logic                  gnt_found;
    logic [ID_BITS-1:0]    gnt_idx;
    logic [ADDR_BITS-1:0]  gnt_addr;
    logic                  credit_ok;
    logic                  collide;
    logic                  issue;
    logic                  push;
    logic                  pop;

    // Reads issued but not yet consumed: two pipeline stages plus FIFO occupancy.
    assign credit_ok = (int'(count_q) + int'(v1_q) + int'(v2_q)) < FIFO_DEPTH;

    always_comb begin
        int idx;
        // NOTE: combinational blocks use blocking assignments and default every output first so no latch is inferred.
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        gnt_addr  = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_BITS'(idx);
                gnt_addr  = req_addr[idx*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

`ifdef ELIXIRCHIP_BRAM_ARB_COLLISION_STALL_EN
    // Hold off a read that hits the address being written this cycle so it returns post-write data.
    assign collide = wr_en && (wr_addr == gnt_addr);
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr};
    assign collide   = 1'b0;
`endif

    assign issue = gnt_found && credit_ok && !collide;

    // Issue-side outputs are combinational, so they are masked directly while reset is held.
    always_comb begin
        req_ready = '0;
        if (issue && reset_n) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign ram_en     = issue && reset_n;
    assign ram_addr   = (issue && reset_n) ? gnt_addr : '0;
    assign ram_regcke = v1_q;

    assign push = v2_q;
    assign pop  = rsp_valid_q && rsp_ready;

    always_comb begin
        rr_d   = issue ? gnt_idx : rr_q;
        v1_d   = issue;
        tag1_d = issue ? gnt_idx : tag1_q;
        v2_d   = v1_q;
        tag2_d = tag1_q;

        count_d  = count_q + CNT_BITS'(push) - CNT_BITS'(pop);
        wr_ptr_d = push ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;

        rsp_valid_d = (count_d != '0);
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        // Output registers mirror the head; bypass the push when it becomes the new head.
        if ((count_q == '0) || (pop && (count_q == CNT_BITS'(1)))) begin
            if (push) begin
                rsp_id_d   = tag2_q;
                rsp_data_d = ram_dout;
            end
        end else if (pop) begin
            rsp_id_d   = fifo_id_mem[rd_ptr_d];
            rsp_data_d = fifo_data_mem[rd_ptr_d];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q        <= ID_BITS'(NUM_REQ - 1);
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            tag1_q      <= '0;
            tag2_q      <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_q        <= rr_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // NOTE: FIFO storage has no reset; pointers and count define validity, and this maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_mem[wr_ptr_q]   <= tag2_q;
            fifo_data_mem[wr_ptr_q] <= ram_dout;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_elixirchip_es1_bram_read_arbiter.sv
// Self-checking bench for elixirchip_es1_bram_read_arbiter with a READ_FIRST RAMB18E2 (DOUT_REGS=1) model.
// Honours ELIXIRCHIP_BRAM_ARB_COLLISION_STALL_EN when the design is built with it.
module tb_elixirchip_es1_bram_read_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ID_BITS    = 2;
    localparam int ADDR_BITS  = 10;
    localparam int DATA_WIDTH = 18;
    localparam int FIFO_DEPTH = 4;

    logic                         clk = 1'b0;
    logic                         reset_n;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [ID_BITS-1:0]           rsp_id;
    logic [DATA_WIDTH-1:0]        rsp_data;
    logic                         wr_en;
    logic [ADDR_BITS-1:0]         wr_addr;
    logic                         ram_en;
    logic                         ram_regcke;
    logic [ADDR_BITS-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0]        ram_dout;

    int checks   = 0;
    int failures = 0;

    logic [DATA_WIDTH-1:0]         ram_mem [1024];
    logic [DATA_WIDTH-1:0]         ram_lat;
    logic [ID_BITS+DATA_WIDTH-1:0] exp_q [$];

    elixirchip_es1_bram_read_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS),
        .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .ram_en(ram_en), .ram_regcke(ram_regcke),
        .ram_addr(ram_addr), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM read port: enable latches the array (old data on same-edge write), regcke loads the output register.
    always @(posedge clk) begin
        if (ram_en) ram_lat <= ram_mem[ram_addr];
        if (ram_regcke) ram_dout <= ram_lat;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 4'hF;
        req_addr  = 40'($urandom) ^ {8'd0, 32'($urandom)};
        rsp_ready = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        repeat (2) @(posedge clk);
        #3;
        checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL reset_req_ready got=%h exp=0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        checks++; if (rsp_data !== 18'd0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
        checks++; if (ram_regcke !== 1'b0) begin failures++; $display("FAIL reset_ram_regcke got=%b exp=0", ram_regcke); end
        checks++; if (ram_addr !== 10'd0) begin failures++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready = 1'b1;
        ram_mem[10'h155] = 18'h2A5A5;
        req_addr[2*ADDR_BITS +: ADDR_BITS] = 10'h155;
        req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
        checks++; if (ram_en !== 1'b1 || ram_addr !== 10'h155) begin failures++; $display("FAIL single_issue en=%b addr=%h exp en=1 addr=155", ram_en, ram_addr); end
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        checks++; if (ram_regcke !== 1'b1 || ram_en !== 1'b0) begin failures++; $display("FAIL single_regcke regcke=%b en=%b exp 1/0", ram_regcke, ram_en); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || ram_regcke !== 1'b0) begin failures++; $display("FAIL single_t2 rsp_valid=%b regcke=%b exp 0/0", rsp_valid, ram_regcke); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 18'h2A5A5) begin
            failures++; $display("FAIL single_rsp valid=%b id=%0d data=%h exp 1/2/2a5a5", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 18'h2A5A5) begin
            failures++; $display("FAIL single_empty_hold valid=%b data=%h exp 0/2a5a5", rsp_valid, rsp_data); end
    endtask

    task automatic test_round_robin();
        int nrsp = 0;
        logic [ID_BITS+DATA_WIDTH-1:0] e;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_BITS +: ADDR_BITS] = 10'(10'h040 + i * 3);
        req_valid = 4'hF;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (n < 12) begin
                checks++; if (req_ready !== 4'(1 << (n % 4)) || ram_addr !== 10'(10'h040 + (n % 4) * 3)) begin
                    failures++; $display("FAIL rr_grant cycle=%0d got=%b addr=%h exp=%b", n, req_ready, ram_addr, 4'(1 << (n % 4))); end
                exp_q.push_back({2'(n % 4), ram_mem[10'(10'h040 + (n % 4) * 3)]});
            end
            if (rsp_valid) begin
                nrsp++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++; if ({rsp_id, rsp_data} !== e) begin failures++; $display("FAIL rr_rsp got=%0d/%h exp=%0d/%h", rsp_id, rsp_data, e[19:18], e[17:0]); end
            end
            @(posedge clk); #1;
            if (n == 11) req_valid = '0;
        end
        checks++; if (nrsp !== 12) begin failures++; $display("FAIL rr_rsp_count got=%0d exp=12", nrsp); end
    endtask

    task automatic test_backpressure();
        logic [ID_BITS+DATA_WIDTH-1:0] e;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_BITS +: ADDR_BITS] = 10'(10'h200 + i * 7);
        req_valid = 4'hF;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checks++; if (req_ready !== ((n < FIFO_DEPTH) ? 4'(1 << n) : 4'h0)) begin
                failures++; $display("FAIL bp_grant cycle=%0d got=%b exp=%b", n, req_ready, (n < FIFO_DEPTH) ? 4'(1 << n) : 4'h0); end
            if (n < FIFO_DEPTH) exp_q.push_back({2'(n), ram_mem[10'(10'h200 + n * 7)]});
            @(posedge clk); #1;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (n < FIFO_DEPTH) begin
                e = exp_q.pop_front();
                checks++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_data} !== e) begin
                    failures++; $display("FAIL bp_drain n=%0d valid=%b got=%0d/%h exp=%0d/%h", n, rsp_valid, rsp_id, rsp_data, e[19:18], e[17:0]); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_extra n=%0d valid=%b exp=0", n, rsp_valid); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_collision();
        logic got = 1'b0;
        logic [DATA_WIDTH-1:0] exp_data;
        do_reset();
        rsp_ready = 1'b1;
        ram_mem[10'h010] = 18'h3FFFF;
        req_addr[1*ADDR_BITS +: ADDR_BITS] = 10'h010;
        req_valid = 4'b0010;
        wr_en     = 1'b1;
        wr_addr   = 10'h010;
        @(negedge clk);
`ifdef ELIXIRCHIP_BRAM_ARB_COLLISION_STALL_EN
        exp_data = 18'h00123;
        checks++; if (req_ready !== 4'b0000 || ram_en !== 1'b0) begin failures++; $display("FAIL coll_stall ready=%b en=%b exp 0000/0", req_ready, ram_en); end
`else
        exp_data = 18'h3FFFF;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL coll_grant got=%b exp=0010", req_ready); end
`endif
        @(posedge clk);
        ram_mem[10'h010] <= 18'h00123;
        #1 wr_en = 1'b0;
`ifdef ELIXIRCHIP_BRAM_ARB_COLLISION_STALL_EN
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL coll_late_grant got=%b exp=0010", req_ready); end
        @(posedge clk); #1;
`endif
        req_valid = '0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                checks++; if (rsp_id !== 2'd1 || rsp_data !== exp_data) begin
                    failures++; $display("FAIL coll_rsp got=%0d/%h exp=1/%h", rsp_id, rsp_data, exp_data); end
            end
        end
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL coll_rsp_timeout got=%b exp=1", got); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_BITS +: ADDR_BITS] = 10'(10'h300 + i);
        req_valid = 4'b0111;
        repeat (3) begin @(posedge clk); #1; end
        req_valid = '0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || ram_regcke !== 1'b1) begin failures++; $display("FAIL midop_state valid=%b regcke=%b exp 1/1", rsp_valid, ram_regcke); end
        #2 reset_n = 1'b0;
        req_valid = 4'hF;
        #1;
        checks++; if ({req_ready, rsp_valid, rsp_id, rsp_data, ram_en, ram_regcke, ram_addr} !== '0) begin
            failures++; $display("FAIL midop_reset ready=%b v=%b id=%0d d=%h en=%b cke=%b a=%h exp all 0",
                                 req_ready, rsp_valid, rsp_id, rsp_data, ram_en, ram_regcke, ram_addr); end
        @(posedge clk); #1 reset_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL midop_first_grant got=%b exp=0001", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        for (int n = 1; n < 3; n++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midop_stale n=%0d valid=%b exp=0", n, rsp_valid); end
        end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== ram_mem[10'h300]) begin
            failures++; $display("FAIL midop_rsp valid=%b id=%0d data=%h exp 1/0/%h", rsp_valid, rsp_id, rsp_data, ram_mem[10'h300]); end
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0]   mv = '0;
        logic [ADDR_BITS-1:0] ma [NUM_REQ];
        int wait_cnt [NUM_REQ];
        int outstanding = 0;
        int rr_m = NUM_REQ - 1;
        int g;
        logic [ID_BITS+DATA_WIDTH-1:0] e;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin wait_cnt[i] = 0; ma[i] = '0; end
        for (int cyc = 0; cyc < 10000 + 12; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (cyc < 10000 && !mv[i] && $urandom_range(0, 1) == 1) begin mv[i] = 1'b1; ma[i] = 10'($urandom); end
            req_valid = mv;
            for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_BITS +: ADDR_BITS] = ma[i];
            rsp_ready = (cyc >= 10000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = -1;
            if (outstanding < FIFO_DEPTH)
                for (int k = 1; k <= NUM_REQ; k++)
                    if (g < 0 && mv[(rr_m + k) % NUM_REQ]) g = (rr_m + k) % NUM_REQ;
            checks++; if (req_ready !== ((g >= 0) ? 4'(1 << g) : 4'h0)) begin
                failures++; $display("FAIL rand_grant cycle=%0d got=%b exp_idx=%0d", cyc, req_ready, g); end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL rand_unexpected_rsp cycle=%0d got=%0d/%h exp none", cyc, rsp_id, rsp_data); end
                else begin
                    e = exp_q.pop_front();
                    outstanding--;
                    if ({rsp_id, rsp_data} !== e) begin failures++; $display("FAIL rand_rsp cycle=%0d got=%0d/%h exp=%0d/%h", cyc, rsp_id, rsp_data, e[19:18], e[17:0]); end
                end
            end
            if (g >= 0) begin
                checks++; if (ram_addr !== ma[g] || wait_cnt[g] > NUM_REQ) begin
                    failures++; $display("FAIL rand_issue cycle=%0d addr=%h exp=%h waited=%0d", cyc, ram_addr, ma[g], wait_cnt[g]); end
                exp_q.push_back({2'(g), ram_mem[ma[g]]});
                for (int i = 0; i < NUM_REQ; i++) if (i != g && mv[i]) wait_cnt[i]++;
                wait_cnt[g] = 0;
                mv[g] = 1'b0;
                rr_m = g;
                outstanding++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL rand_drain left=%0d valid=%b exp 0/0", exp_q.size(), rsp_valid); end
    endtask

    initial begin
        reset_n = 1'b0;
        for (int a = 0; a < 1024; a++) ram_mem[a] = 18'($urandom);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_collision();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
